pipelined_csel_adder: RTL and testbench
=======================================

// Module: pipelined_csel_adder
// PURPOSE
//   Parametrised, pipelined carry-select adder/subtractor; successor to the single-cycle 64-bit adder.
//   Operand width is split into STAGES equal chunks. The input stage precomputes both carry-in
//   variants (0/1) of every chunk; pipeline stage k then selects the chunk-k result.
//   Valid/ready handshake on both sides, with a tag carried alongside. Sits in the datapath ALU slice.
// PARAMETERS
//   W       64  operand/result width; must be divisible by STAGES
//   STAGES  4   pipeline depth = chunk count; chunk width C = W/STAGES; legal 1..W
//   TAG_W   4   width of the opaque tag carried with each operation
// PORTS
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   in_valid   in   1      operation offered
//   in_ready   out  1      operation accepted when in_valid && in_ready
//   op_sub     in   1      0: s=a+b+carry_in; 1: s=a-b-carry_in (carry_in acts as borrow)
//   a, b       in   W      operands
//   carry_in   in   1      carry (add) / borrow (sub)
//   in_tag     in   TAG_W  tag, returned unchanged with the result
//   out_valid  out  1      result available
//   out_ready  in   1      consumer accepts when out_valid && out_ready
//   s          out  W      result
//   carry_out  out  1      raw carry out of bit W-1; in sub mode 1 = no borrow
//   overflow   out  1      signed (two's-complement) overflow of the W-bit operation
//   out_tag    out  TAG_W  tag of the operation in s
// BEHAVIOUR
//   - Reset (sync, high): all stage valid bits cleared; out_valid=0; s, carry_out, overflow and
//     out_tag all 0. in_ready=0 while reset is high. In-flight operations are discarded and never emitted.
//   - Arithmetic: bb = op_sub ? ~b : b; ci = op_sub ? ~carry_in : carry_in.
//     {carry_out,s} = {1'b0,a} + {1'b0,bb} + ci, computed in W+1 bits (no truncation before bit W).
//     overflow = (a[W-1]==bb[W-1]) && (s[W-1]!=a[W-1]).
//   - Carry-select: for chunk j the input stage computes sum0_j/cout0_j (carry-in 0) and sum1_j/cout1_j (carry-in 1).
//     Stage k selects chunk k using the resolved carry from chunk k-1 (chunk 0 uses ci).
//     Resolved chunks and unresolved sum0/sum1 pairs travel forward in skewed registers.
//     No full-width carry chain exists in any single stage.
//   - Latency: exactly STAGES cycles from accept (cycle N) to out_valid (cycle N+STAGES), with no stall.
//   - Throughput: one operation per cycle when out_ready=1.
//   - Flow control: global stall. stall = out_valid && !out_ready. When stall=1 every pipeline
//     register holds and in_ready=0; otherwise in_ready=1 (outside reset). Bubbles are not collapsed.
//   - Output hold: while out_valid && !out_ready, s, carry_out, overflow and out_tag stay stable.
//   - Ordering: results emerge in acceptance order; no loss, no duplication.
//   - Simultaneous events: out_ready rising in the same cycle as a new in_valid means the pipeline
//     advances and the new operation is accepted. reset has priority over every other input.
//   - Wrap-around: results are modulo 2^W; the lost bit is reported only in carry_out.
//   - STAGES=1: degenerate case, one registered stage, latency 1.
// TESTING (W=64, STAGES=4 unless noted; latency 4)
//   1. add, a=FFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> s=0, carry_out=1, overflow=0, out_valid 4 cycles later
//   2. add, a=0000_0000_FFFF_FFFF, b=1, cin=0 -> s=0000_0001_0000_0000, carry_out=0 (cross-chunk carry)
//   3. add, a=7FFF_FFFF_FFFF_FFFF, b=1 -> s=8000_0000_0000_0000, overflow=1, carry_out=0;
//      sub, a=5, b=7, cin=0 -> s=FFFF_FFFF_FFFF_FFFE, carry_out=0, overflow=0
//   4. 8 back-to-back ops, tags 0..7, out_ready=0 for 3 cycles mid-stream -> in_ready=0 and
//      outputs stable during the stall; tags 0..7 returned in order with correct sums
//   5. reset for 1 cycle with 3 ops in flight -> out_valid=0 next cycle; none of the 3 ever emitted;
//      a new op accepted after reset returns correctly
//   6. formal (W=16, STAGES=4) -> assert {carry_out,s}, overflow and out_tag equal a gold model of
//      the accepted op, delivered in order; cover a stall with a cross-chunk carry in flight

Source files
------------

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: chunk sums for both carry-in values are
// precomputed on entry, then each stage resolves one chunk from the carry of the chunk below.
module pipelined_csel_adder #(
  parameter int W      = 64,
  parameter int STAGES = 4,
  parameter int TAG_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             carry_in,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     s,
  output logic             carry_out,
  output logic             overflow,
  output logic [TAG_W-1:0] out_tag
);

  localparam int C = W / STAGES;

  // One pipeline slot: unresolved sum pairs, the resolved low part, and the running carry.
  typedef struct packed {
    logic              valid;
    logic [W-1:0]      sum0;
    logic [W-1:0]      sum1;
    logic [STAGES-1:0] c0;
    logic [STAGES-1:0] c1;
    logic [W-1:0]      res;
    logic              carry;
    logic              a_msb;
    logic              bb_msb;
    logic [TAG_W-1:0]  tag;
  } stage_t;

  function automatic stage_t resolve(input stage_t x, input int k);
    stage_t r;
    r = x;
    r.res[k*C +: C] = x.carry ? x.sum1[k*C +: C] : x.sum0[k*C +: C];
    r.carry         = x.carry ? x.c1[k] : x.c0[k];
    return r;
  endfunction

  logic [W-1:0] bb;
  logic         ci;
  logic [C:0]   t0;
  logic [C:0]   t1;
  logic         stall;
  stage_t       entry;
  stage_t       pipe_d [STAGES];
  stage_t       pipe_q [STAGES];

  assign bb = op_sub ? ~b : b;
  assign ci = op_sub ? ~carry_in : carry_in;

  always_comb begin
    entry        = '0;
    t0           = '0;
    t1           = '0;
    entry.valid  = in_valid;
    entry.carry  = ci;
    entry.a_msb  = a[W-1];
    entry.bb_msb = bb[W-1];
    entry.tag    = in_tag;
    for (int j = 0; j < STAGES; j++) begin
      t0 = {1'b0, a[j*C +: C]} + {1'b0, bb[j*C +: C]};
      t1 = {1'b0, a[j*C +: C]} + {1'b0, bb[j*C +: C]} + {{C{1'b0}}, 1'b1};
      entry.sum0[j*C +: C] = t0[C-1:0];
      entry.c0[j]          = t0[C];
      entry.sum1[j*C +: C] = t1[C-1:0];
      entry.c1[j]          = t1[C];
    end
  end

  always_comb begin
    pipe_d[0] = resolve(entry, 0);
    for (int k = 1; k < STAGES; k++) begin
      pipe_d[k] = resolve(pipe_q[k-1], k);
    end
  end

  // Handshake: a transfer happens on a rising edge where valid && ready. The whole
  // pipeline freezes while the output is valid but not taken; bubbles are not squeezed out.
  assign out_valid = pipe_q[STAGES-1].valid;
  assign stall     = out_valid && !out_ready;
  assign in_ready  = !reset && !stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) pipe_q[k] <= '0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) pipe_q[k] <= pipe_d[k];
    end
  end

  assign s         = pipe_q[STAGES-1].res;
  assign carry_out = pipe_q[STAGES-1].carry;
  assign out_tag   = pipe_q[STAGES-1].tag;
  assign overflow  = (pipe_q[STAGES-1].a_msb == pipe_q[STAGES-1].bb_msb) &&
                     (s[W-1] != pipe_q[STAGES-1].a_msb);

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Bench for pipelined_csel_adder: directed vectors, a whole-word arithmetic model with an
// in-order expected queue, and literal checks on latency and results.
module tb_pipelined_csel_adder;
  localparam int W      = 64;
  localparam int STAGES = 4;
  localparam int TAG_W  = 4;
  localparam int EW     = W + 2 + TAG_W;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             carry_in;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     s;
  logic             carry_out;
  logic             overflow;
  logic [TAG_W-1:0] out_tag;

  pipelined_csel_adder #(.W(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .carry_in(carry_in), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .carry_out(carry_out),
    .overflow(overflow), .out_tag(out_tag)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int outs_seen = 0;
  logic [EW-1:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [EW-1:0] model(input logic sub, input logic [W-1:0] av,
                                          input logic [W-1:0] bv, input logic cin,
                                          input logic [TAG_W-1:0] tg);
    logic [W-1:0] bbv;
    logic         civ;
    logic [W:0]   full;
    logic         ov;
    bbv  = sub ? ~bv : bv;
    civ  = sub ? ~cin : cin;
    full = {1'b0, av} + {1'b0, bbv} + {{W{1'b0}}, civ};
    ov   = (av[W-1] == bbv[W-1]) && (full[W-1] != av[W-1]);
    return {full, ov, tg};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // scoreboard / compare process
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_out = '0;
  always @(negedge clock) begin
    logic [EW-1:0] cur;
    logic [EW-1:0] head;
    cur = {carry_out, s, overflow, out_tag};
    if (reset) begin
      exp_q.delete();
      check("in_ready_during_reset", in_ready, 0);
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_data_hold", cur, prev_out);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output: got %0h expected no output", cur);
        end else begin
          head = exp_q.pop_front();
          check("result", cur, head);
          outs_seen++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(op_sub, a, b, carry_in, in_tag));
      prev_stall = out_valid && !out_ready;
      prev_out   = cur;
    end
  end

  // driver tasks
  task automatic send(input logic sub, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic cin, input logic [TAG_W-1:0] tg, output int acc_cyc);
    logic acc;
    acc      = 1'b0;
    acc_cyc  = 0;
    op_sub   = sub;
    a        = av;
    b        = bv;
    carry_in = cin;
    in_tag   = tg;
    in_valid = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clock);
      acc     = in_ready;
      acc_cyc = cyc;
      @(posedge clock);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic wait_out(output int out_cyc, output logic found);
    found   = 1'b0;
    out_cyc = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clock);
      if (out_valid) begin
        found   = 1'b1;
        out_cyc = cyc;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL output_timeout: got out_valid=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic run_single(input string name, input logic sub, input logic [W-1:0] av,
                            input logic [W-1:0] bv, input logic cin, input logic [TAG_W-1:0] tg,
                            input logic [W-1:0] es, input logic eco, input logic eov);
    int   ac;
    int   oc;
    logic found;
    send(sub, av, bv, cin, tg, ac);
    in_valid = 1'b0;
    wait_out(oc, found);
    if (found) begin
      check({name, "_latency"}, oc - ac, STAGES);
      check({name, "_s"}, s, es);
      check({name, "_carry_out"}, carry_out, eco);
      check({name, "_overflow"}, overflow, eov);
      check({name, "_tag"}, out_tag, tg);
    end
    @(posedge clock);
    #1;
  endtask

  logic [W-1:0] burst_a [8] = '{64'h0000_0000_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0,
                                64'hFFFF_0000_FFFF_0000, 64'h8000_0000_0000_0000,
                                64'h0000_0000_0000_0010, 64'h7FFF_FFFF_FFFF_FFFF,
                                64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_0F0F_0F0F};
  logic [W-1:0] burst_b [8] = '{64'h0000_0000_0000_0001, 64'h0FED_CBA9_8765_4321,
                                64'h0000_FFFF_0001_0000, 64'h0000_0000_0000_0001,
                                64'h0000_0000_0000_0020, 64'h8000_0000_0000_0000,
                                64'h0000_0000_0000_0001, 64'hF0F0_F0F0_F0F0_F0F0};
  logic         burst_sub [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic         burst_cin [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    int ac;
    int outs_before;
    reset     = 1'b1;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    a         = '0;
    b         = '0;
    carry_in  = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_out_valid", out_valid, 0);
    check("reset_s", s, 0);
    check("reset_carry_out", carry_out, 0);
    check("reset_overflow", overflow, 0);
    check("reset_out_tag", out_tag, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    run_single("all_ones_plus_cin", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 4'h1,
               64'h0, 1'b1, 1'b0);
    run_single("cross_chunk", 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 4'h2,
               64'h0000_0001_0000_0000, 1'b0, 1'b0);
    run_single("pos_overflow", 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 4'h3,
               64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_single("sub_5_7", 1'b1, 64'h5, 64'h7, 1'b0, 4'h4,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_single("sub_0_0", 1'b1, 64'h0, 64'h0, 1'b0, 4'h5, 64'h0, 1'b1, 1'b0);
    run_single("sub_min_1", 1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 4'h6,
               64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    run_single("sub_borrow_in", 1'b1, 64'h0, 64'h0, 1'b1, 4'h7,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    // back-to-back burst with a mid-stream consumer stall
    outs_before = outs_seen;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(burst_sub[i], burst_a[i], burst_b[i], burst_cin[i], TAG_W'(i), ac);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clock);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 out_ready = 1'b1;
      end
    join
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clock);
    #1;
    check("burst_drained", exp_q.size(), 0);
    check("burst_count", outs_seen - outs_before, 8);

    // reset with three operations in flight
    for (int i = 0; i < 3; i++) begin
      send(1'b0, burst_a[i], burst_b[i], 1'b0, TAG_W'(8 + i), ac);
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("post_reset_out_valid", out_valid, 0);
    outs_before = outs_seen;
    repeat (8) @(posedge clock);
    #1;
    check("flushed_never_emitted", outs_seen - outs_before, 0);
    run_single("after_reset", 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1,
               4'hC, 64'h0000_0001_0000_0001, 1'b0, 1'b0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
